hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 tb/tb_hazard_scoreboard.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register busy counters, RAW/WAW stall and forwarding-mux selects.
// Ports: clk, reset (async, active-low); decode sources src_key/src_valid;
//   issue_valid/issue_rd_en/issue_rd_key/issue_lat; flush; forwarding points stg_rd_key/stg_rd_en;
//   outputs src_sel (per-source mux select), stall, stall_count.
// Optional feature: define HAZARD_STALL_STATS_EN to build the stall cycle counter.
module hazard_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int KEY_W      = 5,
    parameter int LAT_W      = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_SRC*KEY_W-1:0]                   src_key,
    input  logic [NUM_SRC-1:0]                         src_valid,
    input  logic                                       issue_valid,
    input  logic                                       issue_rd_en,
    input  logic [KEY_W-1:0]                           issue_rd_key,
    input  logic [LAT_W-1:0]                           issue_lat,
    input  logic                                       flush,
    input  logic [FWD_STAGES*KEY_W-1:0]                stg_rd_key,
    input  logic [FWD_STAGES-1:0]                      stg_rd_en,
    output logic [NUM_SRC*$clog2(FWD_STAGES+1)-1:0]    src_sel,
    output logic                                       stall,
    output logic [31:0]                                stall_count
);

    localparam int NUM_REGS = 2**KEY_W;
    localparam int SEL_W    = $clog2(FWD_STAGES+1);

    logic [LAT_W-1:0] busy [NUM_REGS];
    logic [LAT_W-1:0] rd_busy;
    logic [NUM_SRC-1:0] raw;
    logic [KEY_W-1:0] key_tmp;
    logic [SEL_W-1:0] sel_tmp;
    logic waw;
    logic issue;
    logic do_load;

    // RAW: a busy count of 1 means the value reaches forwarding point 0
    // this cycle, so only counts above 1 must stall.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i]
                && src_key[i*KEY_W +: KEY_W] != '0
                && busy[src_key[i*KEY_W +: KEY_W]] > LAT_W'(1)) begin
                raw[i] = 1'b1;
            end
        end
    end

    // WAW: a younger write must not land before an older one still in flight.
    always_comb begin
        rd_busy = busy[issue_rd_key];
        waw = issue_rd_en
            && issue_rd_key != '0
            && rd_busy != '0
            && issue_lat < rd_busy;
    end

    assign stall   = issue_valid & ~flush & ((|raw) | waw);
    assign issue   = issue_valid & ~flush & ~stall;
    assign do_load = issue & issue_rd_en & (issue_rd_key != '0);

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        src_sel = '0;
        key_tmp = '0;
        sel_tmp = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            key_tmp = src_key[i*KEY_W +: KEY_W];
            sel_tmp = '0;
            for (int j = FWD_STAGES - 1; j >= 0; j--) begin
                if (key_tmp != '0
                    && stg_rd_en[j]
                    && stg_rd_key[j*KEY_W +: KEY_W] == key_tmp) begin
                    sel_tmp = SEL_W'(j + 1);
                end
            end
            src_sel[i*SEL_W +: SEL_W] = sel_tmp;
        end
    end

    // Register 0 is never loaded because do_load excludes key 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (do_load && issue_rd_key == KEY_W'(r)) begin
                    busy[r] <= issue_lat;
                end else if (busy[r] != '0) begin
                    busy[r] <= busy[r] - LAT_W'(1);
                end
            end
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard against a per-register
// countdown model; all comparisons go through chk.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  src_key;
    logic [1:0]  src_valid;
    logic        issue_valid;
    logic        issue_rd_en;
    logic [4:0]  issue_rd_key;
    logic [3:0]  issue_lat;
    logic        flush;
    logic [9:0]  stg_rd_key;
    logic [1:0]  stg_rd_en;
    logic [3:0]  src_sel;
    logic        stall;
    logic [31:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    int mb[32];
    int mcount;
    bit exp_stall;
    int exp_sel[2];
    int obs_stall;
    int obs_sel[2];

    hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .src_key      (src_key),
        .src_valid    (src_valid),
        .issue_valid  (issue_valid),
        .issue_rd_en  (issue_rd_en),
        .issue_rd_key (issue_rd_key),
        .issue_lat    (issue_lat),
        .flush        (flush),
        .stg_rd_key   (stg_rd_key),
        .stg_rd_en    (stg_rd_en),
        .src_sel      (src_sel),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_count();
`ifdef HAZARD_STALL_STATS_EN
        return mcount;
`else
        return 0;
`endif
    endfunction

    function automatic void predict();
        bit hz;
        int k;
        int rd;
        hz = 0;
        for (int i = 0; i < 2; i++) begin
            k = int'(src_key[i*5 +: 5]);
            if (src_valid[i] && k != 0 && mb[k] > 1) hz = 1;
            exp_sel[i] = 0;
            if (k != 0) begin
                for (int j = 1; j >= 0; j--) begin
                    if (stg_rd_en[j] && int'(stg_rd_key[j*5 +: 5]) == k)
                        exp_sel[i] = j + 1;
                end
            end
        end
        rd = int'(issue_rd_key);
        if (issue_rd_en && rd != 0 && mb[rd] != 0 && int'(issue_lat) < mb[rd])
            hz = 1;
        exp_stall = issue_valid && !flush && hz;
    endfunction

    task automatic idle();
        src_key = '0; src_valid = '0;
        issue_valid = 0; issue_rd_en = 0;
        issue_rd_key = '0; issue_lat = 4'd1;
        flush = 0; stg_rd_key = '0; stg_rd_en = '0;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step(input string tag);
        bit iss;
        #1;
        predict();
        obs_stall  = int'(stall);
        obs_sel[0] = int'(src_sel[1:0]);
        obs_sel[1] = int'(src_sel[3:2]);
        chk({tag, ".stall"}, stall, exp_stall);
        chk({tag, ".sel0"}, src_sel[1:0], exp_sel[0]);
        chk({tag, ".sel1"}, src_sel[3:2], exp_sel[1]);
        chk({tag, ".cnt"}, stall_count, exp_count());
        @(posedge clk);
        if (exp_stall) mcount++;
        iss = issue_valid && !flush && !exp_stall;
        for (int r = 1; r < 32; r++)
            if (mb[r] > 0) mb[r]--;
        if (iss && issue_rd_en && issue_rd_key != 0)
            mb[issue_rd_key] = int'(issue_lat);
        @(negedge clk);
    endtask

    // Asserts reset between edges, checks the async clear, releases at next falling edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        for (int r = 0; r < 32; r++) mb[r] = 0;
        mcount = 0;
        chk({tag, ".stall"}, stall, 0);
        chk({tag, ".cnt"}, stall_count, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic issue(input int rd, input int lat);
        idle();
        issue_valid = 1; issue_rd_en = 1;
        issue_rd_key = 5'(rd); issue_lat = 4'(lat);
    endtask

    initial begin
        reset = 1'b1;
        mcount = 0;
        for (int r = 0; r < 32; r++) mb[r] = 0;
        idle();
        @(negedge clk);
        // Reset state, with a read of r9 pending.
        src_key[4:0] = 5'd9; src_valid = 2'b01; issue_valid = 1;
        do_reset("rst0");

        // Issue rd3 lat1, forward from stage 0 next cycle.
        issue(3, 1); step("d35a");
        idle(); issue_valid = 1;
        src_key[4:0] = 5'd3; src_valid = 2'b01;
        stg_rd_key[4:0] = 5'd3; stg_rd_en = 2'b01;
        step("d35b");
        chk("d35.stall", obs_stall, 0);
        chk("d35.sel0", obs_sel[0], 1);

        // Issue rd5 lat3; read when busy is 2, then 1.
        issue(5, 3); step("d36a");
        idle(); step("d36b");
        idle(); issue_valid = 1;
        src_key[9:5] = 5'd5; src_valid = 2'b10;
        step("d36c");
        chk("d36.busy2", obs_stall, 1);
        step("d36d");
        chk("d36.busy1", obs_stall, 0);

        // Forwarding priority.
        idle(); src_key[4:0] = 5'd7;
        stg_rd_key = {5'd7, 5'd7}; stg_rd_en = 2'b11;
        step("d37a");
        chk("d37.both", obs_sel[0], 1);
        stg_rd_en = 2'b10;
        step("d37b");
        chk("d37.old", obs_sel[0], 2);
        src_key = '0; stg_rd_key = '0; stg_rd_en = 2'b11;
        step("d37c");
        chk("d37.zero", obs_sel[0], 0);

        // WAW on busy[4]=3, then the flushed variant.
        issue(4, 4); step("d38a");
        idle(); step("d38b");
        issue(4, 1); step("d38c");
        chk("d38.waw", obs_stall, 1);
        issue(4, 4); step("d38d");
        idle(); step("d38e");
        issue(4, 1); flush = 1; step("d38f");
        chk("d38.flush", obs_stall, 0);
        idle(); issue_valid = 1;
        src_key[4:0] = 5'd4; src_valid = 2'b01;
        step("d38g");
        chk("d38.busy2", obs_stall, 1);
        step("d38h");
        chk("d38.busy1", obs_stall, 0);

        // Reset mid-count on r9.
        issue(9, 5); step("d39a");
        idle(); step("d39b");
        src_key[4:0] = 5'd9; src_valid = 2'b01; issue_valid = 1;
        do_reset("d39r");
        step("d39c");
        chk("d39.after", obs_stall, 0);

        // Three stalled cycles for the stall counter.
        issue(6, 6); step("d40a");
        idle(); issue_valid = 1;
        src_key[4:0] = 5'd6; src_valid = 2'b01;
        for (int i = 0; i < 3; i++) step("d40s");
        idle(); step("d40e");
`ifdef HAZARD_STALL_STATS_EN
        chk("d40.cnt", stall_count, 3);
`else
        chk("d40.cnt", stall_count, 0);
`endif

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            src_key      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_valid    = 2'($urandom);
            issue_valid  = ($urandom % 10) < 8;
            issue_rd_en  = ($urandom % 4) != 0;
            issue_rd_key = 5'($urandom_range(0, 7));
            issue_lat    = (($urandom % 4) == 0) ? 4'($urandom_range(1, 15))
                                                 : 4'($urandom_range(1, 3));
            flush        = ($urandom % 10) == 0;
            stg_rd_key   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            stg_rd_en    = 2'($urandom);
            if (($urandom % 200) == 0) do_reset("rnd.rst");
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
